load_store_unit: RTL and testbench

//  Memory stage beside the execute ALU. It handles the instruction indices the ALU leaves idle:
//   27 LB, 28 LH, 29 LW, 30 LBU, 31 LHU, 32 SB, 33 SH, 34 SW.
//  It computes the effective address, runs one req/ack data-bus transaction and aligns/extends

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit (master) and the memory port (slave).
// Signal names follow the load/store unit's view of the bus.
interface load_store_unit_if;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;

  modport master (
    output o_bus_req,
    output o_bus_we,
    output o_bus_addr,
    output o_bus_be,
    output o_bus_wdata,
    input  i_bus_ack,
    input  i_bus_rdata
  );

  modport slave (
    input  o_bus_req,
    input  o_bus_we,
    input  o_bus_addr,
    input  o_bus_be,
    input  o_bus_wdata,
    output i_bus_ack,
    output i_bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage beside the execute ALU: byte/half/word loads and stores over a single
// req/ack data bus, with alignment checking, lane steering and a bus timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [31:0]       i_instruction,
  input  logic [31:0]       i_IR,
  input  logic [31:0]       i_A,
  input  logic [31:0]       i_B,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_load_regfile,
  output logic [31:0]       o_loaddata,
  output logic              o_misaligned,
  output logic              o_bus_error,
  load_store_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  function automatic logic misaligned_f(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_H:    misaligned_f = off[0];
      SZ_W:    misaligned_f = (off != 2'b00);
      default: misaligned_f = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_f(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_B:    be_f = 4'b0001 << off;
      SZ_H:    be_f = off[1] ? 4'b1100 : 4'b0011;
      default: be_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input size_t sz, input logic [31:0] data);
    case (sz)
      SZ_B:    wdata_f = {4{data[7:0]}};
      SZ_H:    wdata_f = {2{data[15:0]}};
      default: wdata_f = data;
    endcase
  endfunction

  // Picks the addressed lane out of the read word and extends it to 32 bits.
  function automatic logic [31:0] extract_f(input size_t sz, input logic sgn,
                                            input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0]  b8;
    logic [15:0] h16;
    case (off)
      2'd0:    b8 = rdata[7:0];
      2'd1:    b8 = rdata[15:8];
      2'd2:    b8 = rdata[23:16];
      default: b8 = rdata[31:24];
    endcase
    h16 = off[1] ? rdata[31:16] : rdata[15:0];
    case (sz)
      SZ_B:    extract_f = {{24{sgn & b8[7]}}, b8};
      SZ_H:    extract_f = {{16{sgn & h16[15]}}, h16};
      default: extract_f = rdata;
    endcase
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;

  logic               dec_valid_s;
  logic               dec_load_s;
  logic               dec_signed_s;
  size_t              dec_size_s;
  logic [31:0]        imm_i_s;
  logic [31:0]        imm_st_s;
  logic [31:0]        ea_s;

  logic               accept_s;
  logic               done_nxt_s;
  logic               mis_nxt_s;
  logic               err_nxt_s;
  logic               lrf_nxt_s;
  logic               cap_s;

  size_t              size_r;
  logic               signed_r;
  logic               load_r;
  logic [1:0]         off_r;
  logic               busy_r;
  logic               we_r;
  logic [31:0]        addr_r;
  logic [3:0]         be_r;
  logic [31:0]        wdata_r;
  logic               done_r;
  logic               mis_r;
  logic               err_r;
  logic               lrf_r;
  logic [31:0]        loaddata_r;
  logic               unused_s;

  assign unused_s = ^{i_IR[19:12], i_IR[6:0]};

  // Instruction-index decode into access size, direction and extension.
  always_comb begin
    dec_valid_s  = 1'b1;
    dec_load_s   = 1'b1;
    dec_signed_s = 1'b0;
    dec_size_s   = SZ_W;
    case (i_instruction)
      32'd27: begin dec_size_s = SZ_B; dec_signed_s = 1'b1; end
      32'd28: begin dec_size_s = SZ_H; dec_signed_s = 1'b1; end
      32'd29: dec_size_s = SZ_W;
      32'd30: dec_size_s = SZ_B;
      32'd31: dec_size_s = SZ_H;
      32'd32: begin dec_size_s = SZ_B; dec_load_s = 1'b0; end
      32'd33: begin dec_size_s = SZ_H; dec_load_s = 1'b0; end
      32'd34: begin dec_size_s = SZ_W; dec_load_s = 1'b0; end
      default: dec_valid_s = 1'b0;
    endcase
  end

  assign imm_i_s  = {{20{i_IR[31]}}, i_IR[31:20]};
  assign imm_st_s = {{20{i_IR[31]}}, i_IR[31:25], i_IR[11:7]};
  assign ea_s     = i_A + (dec_load_s ? imm_i_s : imm_st_s);

  // Next-state logic; an ack in the final timeout cycle still counts as success.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = {CNT_W{1'b0}};
    accept_s    = 1'b0;
    done_nxt_s  = 1'b0;
    mis_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;
    lrf_nxt_s   = 1'b0;
    cap_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start && dec_valid_s) begin
          accept_s = 1'b1;
          if (misaligned_f(dec_size_s, ea_s[1:0])) begin
            state_nxt_s = ST_DONE;
            done_nxt_s  = 1'b1;
            mis_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.i_bus_ack) begin
          state_nxt_s = ST_DONE;
          done_nxt_s  = 1'b1;
          lrf_nxt_s   = load_r;
          cap_s       = load_r;
        end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt_s = ST_DONE;
          done_nxt_s  = 1'b1;
          err_nxt_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state and timeout counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Request attributes latched at issue and held for the whole bus transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      size_r   <= SZ_B;
      signed_r <= 1'b0;
      load_r   <= 1'b0;
      off_r    <= 2'b00;
      we_r     <= 1'b0;
      addr_r   <= 32'h0000_0000;
      be_r     <= 4'b0000;
      wdata_r  <= 32'h0000_0000;
    end else if (accept_s) begin
      size_r   <= dec_size_s;
      signed_r <= dec_signed_s;
      load_r   <= dec_load_s;
      off_r    <= ea_s[1:0];
      we_r     <= ~dec_load_s;
      addr_r   <= {ea_s[31:2], 2'b00};
      be_r     <= be_f(dec_size_s, ea_s[1:0]);
      wdata_r  <= wdata_f(dec_size_s, i_B);
    end
  end

  // Status pulses and the load result register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mis_r      <= 1'b0;
      err_r      <= 1'b0;
      lrf_r      <= 1'b0;
      loaddata_r <= 32'h0000_0000;
    end else begin
      busy_r <= (state_nxt_s == ST_REQ);
      done_r <= done_nxt_s;
      mis_r  <= mis_nxt_s;
      err_r  <= err_nxt_s;
      lrf_r  <= lrf_nxt_s;
      if (cap_s) begin
        loaddata_r <= extract_f(size_r, signed_r, off_r, bus.i_bus_rdata);
      end
    end
  end

  assign o_busy          = busy_r;
  assign o_done          = done_r;
  assign o_misaligned    = mis_r;
  assign o_bus_error     = err_r;
  assign o_load_regfile  = lrf_r;
  assign o_loaddata      = loaddata_r;
  assign bus.o_bus_req   = busy_r;
  assign bus.o_bus_we    = we_r;
  assign bus.o_bus_addr  = addr_r;
  assign bus.o_bus_be    = be_r;
  assign bus.o_bus_wdata = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts bus attributes and
// results, a negedge monitor compares every cycle, and per-test literals pin the model.
module tb_load_store_unit;

  localparam int TIMEOUT = 256;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [31:0] i_instruction;
  logic [31:0] i_IR;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic        o_busy;
  logic        o_done;
  logic        o_load_regfile;
  logic [31:0] o_loaddata;
  logic        o_misaligned;
  logic        o_bus_error;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_instruction  (i_instruction),
    .i_IR           (i_IR),
    .i_A            (i_A),
    .i_B            (i_B),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_load_regfile (o_load_regfile),
    .o_loaddata     (o_loaddata),
    .o_misaligned   (o_misaligned),
    .o_bus_error    (o_bus_error),
    .bus            (bus_if)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the outstanding access, written by the stimulus side only.
  int          issue_cnt = 0;
  logic        m_mis, m_err, m_ld, m_we;
  logic [31:0] m_addr, m_wdata, m_ldval;
  logic [3:0]  m_be;

  task automatic model_issue(input int idx, input logic [31:0] ir, a, b, rd, input bit timeout);
    int          sz;
    int          off;
    bit          sgn;
    logic [31:0] imm, ea, sh;
    logic [3:0]  mask;
    m_ld = (idx <= 31);
    sz   = (idx == 27 || idx == 30 || idx == 32) ? 1 :
           (idx == 28 || idx == 31 || idx == 33) ? 2 : 4;
    sgn  = (idx == 27 || idx == 28);
    imm  = m_ld ? {{20{ir[31]}}, ir[31:20]} : {{20{ir[31]}}, ir[31:25], ir[11:7]};
    ea   = a + imm;
    off  = int'(ea % 4);
    m_mis   = (ea % sz) != 0;
    m_err   = timeout && !m_mis;
    m_we    = !m_ld;
    m_addr  = ea - (ea % 4);
    mask    = 4'((1 << sz) - 1);
    m_be    = mask << off;
    m_wdata = (sz == 1) ? {4{b[7:0]}} : (sz == 2) ? {2{b[15:0]}} : b;
    sh = rd >> (8 * off);
    if (sz == 1) begin
      if (sgn) m_ldval = 32'($signed(sh[7:0]));
      else     m_ldval = 32'(sh[7:0]);
    end else if (sz == 2) begin
      if (sgn) m_ldval = 32'($signed(sh[15:0]));
      else     m_ldval = 32'(sh[15:0]);
    end else begin
      m_ldval = rd;
    end
    issue_cnt++;
  endtask

  // Per-cycle compare against the model; it owns the retired-access count and last load.
  int          done_cnt = 0;
  logic [31:0] m_last   = 32'h0;
  logic        m_act;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("rst_req", bus_if.o_bus_req, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_done", o_done, 1'b0);
      m_last   = 32'h0;
      done_cnt = issue_cnt;
    end else begin
      m_act = (issue_cnt != done_cnt);
      if (bus_if.o_bus_req) begin
        chk("req_allowed", m_act && !m_mis, 1'b1);
        chk("busy_with_req", o_busy, 1'b1);
        chk("bus_addr", bus_if.o_bus_addr, m_addr);
        chk("bus_we", bus_if.o_bus_we, m_we);
        chk("bus_be", bus_if.o_bus_be, m_be);
        if (m_we) chk("bus_wdata", bus_if.o_bus_wdata, m_wdata);
      end
      if (o_done) begin
        chk("done_allowed", m_act, 1'b1);
        chk("busy_at_done", o_busy, 1'b0);
        chk("misaligned", o_misaligned, m_mis);
        chk("bus_error", o_bus_error, m_err);
        chk("load_regfile", o_load_regfile, m_ld && !m_mis && !m_err);
        if (m_ld && !m_mis && !m_err) begin
          chk("loaddata", o_loaddata, m_ldval);
          m_last = m_ldval;
        end else begin
          chk("loaddata_kept", o_loaddata, m_last);
        end
        done_cnt++;
      end else begin
        chk("no_lrf", o_load_regfile, 1'b0);
        chk("no_mis", o_misaligned, 1'b0);
        chk("no_err", o_bus_error, 1'b0);
        chk("loaddata_hold", o_loaddata, m_last);
      end
    end
  end

  // Observations of the most recent transaction, relative to the start cycle.
  int          r_req_cycles, r_first_req, r_done_cycle, r_lrf_cnt;
  logic        r_mis, r_err, r_we;
  logic [31:0] r_addr, r_wdata, r_ld;
  logic [3:0]  r_be;

  task automatic run_txn(input int idx, input logic [31:0] ir, a, b, rd,
                         input int ack_delay, input int extra_at);
    model_issue(idx, ir, a, b, rd, ack_delay < 0);
    i_instruction = 32'(idx);
    i_IR = ir; i_A = a; i_B = b;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    r_req_cycles = 0; r_first_req = -1; r_done_cycle = -1; r_lrf_cnt = 0;
    r_mis = 1'b0; r_err = 1'b0;
    for (int c = 1; c <= TIMEOUT + 8; c++) begin
      if (ack_delay >= 0 && c == 1 + ack_delay) begin
        bus_if.i_bus_ack   = 1'b1;
        bus_if.i_bus_rdata = rd;
      end
      if (c == extra_at) begin
        i_start = 1'b1; i_instruction = 32'd32;
        i_A = 32'h0000_2000; i_IR = 32'h0; i_B = 32'h0000_005A;
      end
      @(negedge i_clk);
      if (bus_if.o_bus_req) begin
        if (r_first_req < 0) begin
          r_first_req = c;
          r_addr = bus_if.o_bus_addr; r_be = bus_if.o_bus_be;
          r_we = bus_if.o_bus_we; r_wdata = bus_if.o_bus_wdata;
        end
        r_req_cycles++;
      end
      if (o_load_regfile) r_lrf_cnt++;
      if (o_done) begin
        r_done_cycle = c; r_mis = o_misaligned; r_err = o_bus_error; r_ld = o_loaddata;
      end
      @(posedge i_clk); #1;
      bus_if.i_bus_ack   = 1'b0;
      bus_if.i_bus_rdata = 32'hDEAD_BEEF;
      i_start = 1'b0;
      if (r_done_cycle >= 0) break;
    end
    chk("done_within_bound", r_done_cycle >= 0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_instruction = 32'h0;
    i_IR = 32'h0; i_A = 32'h0; i_B = 32'h0;
    bus_if.i_bus_ack = 1'b0; bus_if.i_bus_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge i_clk);
    #1; i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_done", o_done, 1'b0);
    chk("reset_lrf", o_load_regfile, 1'b0);
    chk("reset_loaddata", o_loaddata, 32'h0);
    chk("reset_mis", o_misaligned, 1'b0);
    chk("reset_err", o_bus_error, 1'b0);
    chk("reset_req", bus_if.o_bus_req, 1'b0);
    chk("reset_addr", bus_if.o_bus_addr, 32'h0);
    chk("reset_be", bus_if.o_bus_be, 4'h0);
    @(posedge i_clk); #1;
    // A stray ack while idle must be ignored.
    bus_if.i_bus_ack = 1'b1;
    idle(1);
    bus_if.i_bus_ack = 1'b0;
    idle(1);

    // LB at 0x1003, ack two cycles after req; start during DONE is ignored.
    run_txn(27, 32'h0030_0000, 32'h0000_1000, 32'h0, 32'h8011_2233, 2, 4);
    chk("t1_first_req", r_first_req, 1);
    chk("t1_req_cycles", r_req_cycles, 3);
    chk("t1_done_cycle", r_done_cycle, 4);
    chk("t1_addr", r_addr, 32'h0000_1000);
    chk("t1_be", r_be, 4'b1000);
    chk("t1_we", r_we, 1'b0);
    chk("t1_loaddata", r_ld, 32'hFFFF_FF80);
    chk("t1_lrf_pulses", r_lrf_cnt, 1);
    idle(2);

    run_txn(30, 32'h0030_0000, 32'h0000_1000, 32'h0, 32'h8011_2233, 2, 0);
    chk("t2_lbu", r_ld, 32'h0000_0080);
    // LHU at 0x1002; a start while busy is ignored.
    run_txn(31, 32'h0020_0000, 32'h0000_1000, 32'h0, 32'h8011_2233, 2, 2);
    chk("t2_lhu", r_ld, 32'h0000_8011);
    chk("t2_lhu_be", r_be, 4'b1100);
    idle(2);
    run_txn(28, 32'h0020_0000, 32'h0000_1000, 32'h0, 32'h8011_2233, 0, 0);
    chk("t2_lh", r_ld, 32'hFFFF_8011);
    chk("t2_lh_done_cycle", r_done_cycle, 2);
    // LW whose effective address wraps to zero.
    run_txn(29, 32'h0040_0000, 32'hFFFF_FFFC, 32'h0, 32'h8011_2233, 1, 0);
    chk("t2_lw_wrap_addr", r_addr, 32'h0000_0000);
    chk("t2_lw", r_ld, 32'h8011_2233);
    idle(1);

    run_txn(33, 32'h0000_0100, 32'h0000_0100, 32'h1234_ABCD, 32'h0, 1, 0);
    chk("t3_we", r_we, 1'b1);
    chk("t3_addr", r_addr, 32'h0000_0100);
    chk("t3_be", r_be, 4'b1100);
    chk("t3_wdata", r_wdata, 32'hABCD_ABCD);
    chk("t3_lrf_pulses", r_lrf_cnt, 0);
    chk("t3_loaddata_kept", r_ld, 32'h8011_2233);
    // SB with immediate -1.
    run_txn(32, 32'hFE00_0F80, 32'h0000_2000, 32'h0000_00A5, 32'h0, 0, 0);
    chk("t3_sb_addr", r_addr, 32'h0000_1FFC);
    chk("t3_sb_be", r_be, 4'b1000);
    chk("t3_sb_wdata", r_wdata, 32'hA5A5_A5A5);

    run_txn(29, 32'h0010_0000, 32'h0000_1000, 32'h0, 32'h0, 0, 0);
    chk("t4_done_cycle", r_done_cycle, 1);
    chk("t4_req_cycles", r_req_cycles, 0);
    chk("t4_mis", r_mis, 1'b1);
    chk("t4_lrf_pulses", r_lrf_cnt, 0);
    run_txn(33, 32'h0, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
    chk("t4_sh_mis", r_mis, 1'b1);
    idle(1);

    run_txn(34, 32'h0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, -1, 0);
    chk("t5_req_cycles", r_req_cycles, TIMEOUT);
    chk("t5_done_cycle", r_done_cycle, TIMEOUT + 1);
    chk("t5_err", r_err, 1'b1);
    chk("t5_mis", r_mis, 1'b0);
    idle(2);

    // Reset in the middle of a request, with an ignored start while busy.
    model_issue(29, 32'h0, 32'h0000_3000, 32'h0, 32'h0, 1'b0);
    i_instruction = 32'd29; i_IR = 32'h0; i_A = 32'h0000_3000; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_instruction = 32'd32; i_A = 32'h0000_4000;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(negedge i_clk);
    chk("t6_req_before_rst", bus_if.o_bus_req, 1'b1);
    chk("t6_busy_before_rst", o_busy, 1'b1);
    #2; i_rst_n = 1'b0;
    #1;
    chk("t6_req_dropped", bus_if.o_bus_req, 1'b0);
    chk("t6_busy_dropped", o_busy, 1'b0);
    repeat (2) @(posedge i_clk);
    #1; i_rst_n = 1'b1;
    idle(4);
    chk("t6_loaddata_cleared", o_loaddata, 32'h0);
    run_txn(30, 32'h0030_0000, 32'h0000_1000, 32'h0, 32'h8011_2233, 0, 0);
    chk("t6_recovery_lbu", r_ld, 32'h0000_0080);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
